// File: rtl/matmul_pkg.sv
// Shared types and default sizes for the 8x8 matrix-multiply sequencer.
package matmul_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } matmul_state_t;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 10;
    localparam int DEF_MATRIX_SIZE = 8;

    // Loop-index width; a 1x1 matrix still needs one bit to hold index 0.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IDX_W = idx_width(DEF_MATRIX_SIZE);

endpackage

// File: rtl/matmul_ctrl_mac.sv
// Data-cycle multiply/accumulate for one C element; MATMUL_CTRL_SAT_EN selects the
// full-precision accumulator with clamped write data instead of wrap-around arithmetic.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_valid,
    input  logic                  i_first,
    input  logic                  i_last,
    output logic [DATA_WIDTH-1:0] o_sum,
    output logic                  o_wr_valid
);

`ifdef MATMUL_CTRL_SAT_EN
    localparam int ACC_W = 2 * DATA_WIDTH + $clog2(MATRIX_SIZE) + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_W-1:0]        r_acc;
    logic signed [ACC_W-1:0]        w_acc_nxt;
    logic [DATA_WIDTH-1:0]          w_res;

    function automatic logic [DATA_WIDTH-1:0] clamp(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[DATA_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            return v[DATA_WIDTH-1:0];
        end
    endfunction

    // Signed full-precision product added to the (possibly restarted) running sum.
    always_comb begin
        w_prod    = $signed(i_a) * $signed(i_b);
        w_acc_nxt = (i_first ? {ACC_W{1'b0}} : r_acc) + ACC_W'(w_prod);
        w_res     = clamp(w_acc_nxt);
    end
`else
    localparam int ACC_W = DATA_WIDTH;

    logic [DATA_WIDTH-1:0] w_prod;
    logic [ACC_W-1:0]      r_acc;
    logic [ACC_W-1:0]      w_acc_nxt;
    logic [DATA_WIDTH-1:0] w_res;

    // Low-half product and modulo-2^DATA_WIDTH sum, matching C int overflow.
    always_comb begin
        w_prod    = i_a * i_b;
        w_acc_nxt = (i_first ? {ACC_W{1'b0}} : r_acc) + w_prod;
        w_res     = w_acc_nxt;
    end
`endif

    // Accumulator and registered write data/strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_acc      <= '0;
            o_sum      <= {DATA_WIDTH{1'b0}};
            o_wr_valid <= 1'b0;
        end else begin
            o_wr_valid <= i_valid & i_last;
            if (i_valid) begin
                r_acc <= w_acc_nxt;
            end
            if (i_valid && i_last) begin
                o_sum <= w_res;
            end
        end
    end

endmodule

// File: rtl/matmul_ctrl.sv
// i/j/k loop sequencer: issues A/B reads every cycle, tracks flags through the BRAM
// latency, and hands data to matmul_mac. Optional build macro: MATMUL_CTRL_SAT_EN.
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] a_rd_addr,
    input  logic [DATA_WIDTH-1:0] a_rd_dout,
    output logic [ADDR_WIDTH-1:0] b_rd_addr,
    input  logic [DATA_WIDTH-1:0] b_rd_dout,
    output logic [ADDR_WIDTH-1:0] c_wr_addr,
    output logic [DATA_WIDTH-1:0] c_wr_din,
    output logic                  c_wr_en
);

    localparam int IDX_W = idx_width(MATRIX_SIZE);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MATRIX_SIZE - 1);

    matmul_state_t    r_state;
    logic [IDX_W-1:0] r_i, r_j, r_k;
    logic [IDX_W-1:0] w_nxt_i, w_nxt_j, w_nxt_k;
    logic [IDX_W-1:0] w_iss_i, w_iss_j, w_iss_k;
    logic             w_issue, w_iss_final;
    logic             r_busy, r_done;
    logic [ADDR_WIDTH-1:0] r_a_rd_addr, r_b_rd_addr, r_c_wr_addr;
    logic             r_s1_valid, r_s1_first, r_s1_last;
    logic [IDX_W-1:0] r_s1_i, r_s1_j;
    logic             r_s2_valid, r_s2_first, r_s2_last;
    logic [IDX_W-1:0] r_s2_i, r_s2_j;
    logic [DATA_WIDTH-1:0] w_sum;
    logic             w_wr_valid;

    function automatic logic [ADDR_WIDTH-1:0] flat_addr(input logic [IDX_W-1:0] row,
                                                        input logic [IDX_W-1:0] col);
        return ADDR_WIDTH'(int'(row) * MATRIX_SIZE + int'(col));
    endfunction

    // Counters hold the last issued (i,j,k); the start edge itself issues (0,0,0).
    always_comb begin
        w_nxt_k = (r_k == IDX_MAX) ? {IDX_W{1'b0}} : r_k + IDX_W'(1);
        w_nxt_j = r_j;
        w_nxt_i = r_i;
        if (r_k == IDX_MAX) begin
            w_nxt_j = (r_j == IDX_MAX) ? {IDX_W{1'b0}} : r_j + IDX_W'(1);
            if (r_j == IDX_MAX) begin
                w_nxt_i = (r_i == IDX_MAX) ? {IDX_W{1'b0}} : r_i + IDX_W'(1);
            end else begin
                w_nxt_i = r_i;
            end
        end else begin
            w_nxt_j = r_j;
        end
        if (r_state == S_IDLE) begin
            w_issue = start;
            w_iss_i = {IDX_W{1'b0}};
            w_iss_j = {IDX_W{1'b0}};
            w_iss_k = {IDX_W{1'b0}};
        end else if (r_state == S_RUN) begin
            w_issue = 1'b1;
            w_iss_i = w_nxt_i;
            w_iss_j = w_nxt_j;
            w_iss_k = w_nxt_k;
        end else begin
            w_issue = 1'b0;
            w_iss_i = {IDX_W{1'b0}};
            w_iss_j = {IDX_W{1'b0}};
            w_iss_k = {IDX_W{1'b0}};
        end
        w_iss_final = (w_iss_i == IDX_MAX) && (w_iss_j == IDX_MAX) && (w_iss_k == IDX_MAX);
    end

    // Sequencer FSM with registered busy/done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_i     <= {IDX_W{1'b0}};
            r_j     <= {IDX_W{1'b0}};
            r_k     <= {IDX_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_i     <= {IDX_W{1'b0}};
                        r_j     <= {IDX_W{1'b0}};
                        r_k     <= {IDX_W{1'b0}};
                        r_busy  <= 1'b1;
                        r_state <= w_iss_final ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    r_i <= w_nxt_i;
                    r_j <= w_nxt_j;
                    r_k <= w_nxt_k;
                    if (w_iss_final) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Final write is the one on the strobe once both flag stages are empty.
                    if (w_wr_valid && !r_s1_valid && !r_s2_valid) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read addresses, two-stage flag pipeline matching BRAM latency, C write address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_a_rd_addr <= {ADDR_WIDTH{1'b0}};
            r_b_rd_addr <= {ADDR_WIDTH{1'b0}};
            r_c_wr_addr <= {ADDR_WIDTH{1'b0}};
            r_s1_valid  <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_i      <= {IDX_W{1'b0}};
            r_s1_j      <= {IDX_W{1'b0}};
            r_s2_valid  <= 1'b0;
            r_s2_first  <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s2_i      <= {IDX_W{1'b0}};
            r_s2_j      <= {IDX_W{1'b0}};
        end else begin
            if (w_issue) begin
                r_a_rd_addr <= flat_addr(w_iss_i, w_iss_k);
                r_b_rd_addr <= flat_addr(w_iss_k, w_iss_j);
            end
            r_s1_valid <= w_issue;
            r_s1_first <= w_issue && (w_iss_k == {IDX_W{1'b0}});
            r_s1_last  <= w_issue && (w_iss_k == IDX_MAX);
            r_s1_i     <= w_iss_i;
            r_s1_j     <= w_iss_j;
            r_s2_valid <= r_s1_valid;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s2_i     <= r_s1_i;
            r_s2_j     <= r_s1_j;
            if (r_s2_valid && r_s2_last) begin
                r_c_wr_addr <= flat_addr(r_s2_i, r_s2_j);
            end
        end
    end

    matmul_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .MATRIX_SIZE(MATRIX_SIZE)
    ) u_mac (
        .clock     (clock),
        .reset     (reset),
        .i_a       (a_rd_dout),
        .i_b       (b_rd_dout),
        .i_valid   (r_s2_valid),
        .i_first   (r_s2_first),
        .i_last    (r_s2_last),
        .o_sum     (w_sum),
        .o_wr_valid(w_wr_valid)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign a_rd_addr = r_a_rd_addr;
    assign b_rd_addr = r_b_rd_addr;
    assign c_wr_addr = r_c_wr_addr;
    assign c_wr_din  = w_sum;
    assign c_wr_en   = w_wr_valid;

endmodule
